// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizes for the RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam int LP_D_WIDTH = 8;
  localparam int LP_A_WIDTH = 5;
  localparam int LP_A_MAX   = 32;
  localparam int LP_N_REQ   = 2;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin selector: the requester nearest after `last`
// (wrapping) wins; `last` itself has the lowest priority.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int N_REQ = LP_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             any
);

  // Find the requesting index with the smallest distance from last+1.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    int w_best;
    int w_best_dist;
    int w_dist;
    w_best      = 0;
    w_best_dist = N_REQ;
    w_dist      = 0;
    sel         = '0;
    any         = |req;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = (j + N_REQ - int'(last) - 1) % N_REQ;
      if (req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = j;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      sel[j] = any && (j == w_best);
    end
    sel_idx = IDX_W'(w_best);
  end

endmodule : rr_pick

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a dual-port RAM. One command at a time is
// registered onto the RAM ports; read data returns with a one-hot rvalid.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int D_WIDTH = LP_D_WIDTH,
  parameter int A_WIDTH = LP_A_WIDTH,
  parameter int A_MAX   = LP_A_MAX,
  parameter int N_REQ   = LP_N_REQ,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           we,
  input  logic [N_REQ*A_WIDTH-1:0]   addr,
  input  logic [N_REQ*D_WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [D_WIDTH-1:0]         rdata,
  output logic [N_REQ-1:0]           rvalid,
  output logic                       busy,
  output logic [A_WIDTH-1:0]         ram_address_write,
  output logic [D_WIDTH-1:0]         ram_data_write,
  output logic                       ram_write_enable,
  output logic [A_WIDTH-1:0]         ram_address_read,
  input  logic [D_WIDTH-1:0]         ram_data_read
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [A_WIDTH:0] LP_A_LIMIT = (A_WIDTH + 1)'(A_MAX);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_last;
  logic [N_REQ-1:0]    r_winner_oh;
  logic                r_is_write;
  logic                r_oor;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_rvalid;
  logic [D_WIDTH-1:0]  r_rdata;
  logic [A_WIDTH-1:0]  r_ram_address_write;
  logic [D_WIDTH-1:0]  r_ram_data_write;
  logic                r_ram_write_enable;
  logic [A_WIDTH-1:0]  r_ram_address_read;

  logic [N_REQ-1:0]    w_sel;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_any;
  logic                w_we_sel;
  logic [A_WIDTH-1:0]  w_addr_sel;
  logic [D_WIDTH-1:0]  w_wdata_sel;
  logic                w_in_range;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .last    (r_last),
    .sel     (w_sel),
    .sel_idx (w_sel_idx),
    .any     (w_any)
  );

  // Route the winning requester's command fields out of the packed buses.
  always_comb begin
    w_we_sel    = 1'b0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel[i]) begin
        w_we_sel    = we[i];
        w_addr_sel  = addr[i*A_WIDTH +: A_WIDTH];
        w_wdata_sel = wdata[i*D_WIDTH +: D_WIDTH];
      end
    end
    w_in_range = ({1'b0, w_addr_sel} < LP_A_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, reads walk WAIT/CAPTURE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_is_write) begin
          w_state_nxt = ST_IDLE;
        end else if (RD_LAT == 1) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command, RAM-port, grant and read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last              <= IDX_W'(N_REQ - 1);
      r_winner_oh         <= '0;
      r_is_write          <= 1'b0;
      r_oor               <= 1'b0;
      r_wait_cnt          <= '0;
      r_gnt               <= '0;
      r_rvalid            <= '0;
      r_rdata             <= '0;
      r_ram_address_write <= '0;
      r_ram_data_write    <= '0;
      r_ram_write_enable  <= 1'b0;
      r_ram_address_read  <= '0;
    end else begin
      r_gnt              <= '0;
      r_rvalid           <= '0;
      r_ram_write_enable <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt       <= w_sel;
            r_last      <= w_sel_idx;
            r_winner_oh <= w_sel;
            r_is_write  <= w_we_sel;
            r_oor       <= !w_in_range;
            if (w_we_sel) begin
              r_ram_address_write <= w_addr_sel;
              r_ram_data_write    <= w_wdata_sel;
              // Out-of-range writes are granted but never reach the RAM.
              r_ram_write_enable  <= w_in_range;
            end else begin
              r_ram_address_read  <= w_addr_sel;
            end
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= CNT_W'(RD_LAT - 1);
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          r_rdata  <= r_oor ? '0 : ram_data_read;
          r_rvalid <= r_winner_oh;
        end
        default: begin
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign gnt               = r_gnt;
  assign rvalid            = r_rvalid;
  assign rdata             = r_rdata;
  assign busy              = (r_state != ST_IDLE);
  assign ram_address_write = r_ram_address_write;
  assign ram_data_write    = r_ram_data_write;
  assign ram_write_enable  = r_ram_write_enable;
  assign ram_address_read  = r_ram_address_read;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT=1/A_MAX=32 and
// RD_LAT=3/A_MAX=24), each with a behavioural RAM and an event log.
module tb_ram_arbiter;

  typedef struct {
    int         cyc;
    logic [1:0] who;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n   [2];
  logic [1:0] req     [2];
  logic [1:0] we      [2];
  logic [9:0] addr    [2];
  logic [15:0] wdata  [2];
  logic [1:0] gnt     [2];
  logic [1:0] rvalid  [2];
  logic [7:0] rdata   [2];
  logic       busy    [2];
  logic [4:0] ram_aw  [2];
  logic [7:0] ram_dw  [2];
  logic       ram_we  [2];
  logic [4:0] ram_ar  [2];
  logic [7:0] ram_dr  [2];

  logic [7:0] mem [2][32];
  logic       mem_init = 1'b0;
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  we_cnt [2] = '{0, 0};
  ev_t gq [2][$];
  ev_t rq [2][$];

  always #5 clk = ~clk;

  ram_arbiter #(
    .D_WIDTH (8), .A_WIDTH (5), .A_MAX (32), .N_REQ (2), .RD_LAT (1)
  ) u_dut_a (
    .clk (clk), .rst_n (rst_n[0]), .req (req[0]), .we (we[0]),
    .addr (addr[0]), .wdata (wdata[0]), .gnt (gnt[0]), .rdata (rdata[0]),
    .rvalid (rvalid[0]), .busy (busy[0]), .ram_address_write (ram_aw[0]),
    .ram_data_write (ram_dw[0]), .ram_write_enable (ram_we[0]),
    .ram_address_read (ram_ar[0]), .ram_data_read (ram_dr[0])
  );

  ram_arbiter #(
    .D_WIDTH (8), .A_WIDTH (5), .A_MAX (24), .N_REQ (2), .RD_LAT (3)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n[1]), .req (req[1]), .we (we[1]),
    .addr (addr[1]), .wdata (wdata[1]), .gnt (gnt[1]), .rdata (rdata[1]),
    .rvalid (rvalid[1]), .busy (busy[1]), .ram_address_write (ram_aw[1]),
    .ram_data_write (ram_dw[1]), .ram_write_enable (ram_we[1]),
    .ram_address_read (ram_ar[1]), .ram_data_read (ram_dr[1])
  );

  // Behavioural RAMs (not reset by the arbiter); word 25 of RAM B is preset
  // so an out-of-range read that leaks RAM data is visible.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 32; i++) begin
          mem[d][i] <= 8'h00;
        end
      end
      mem[1][25] <= 8'h5A;
      mem_init   <= 1'b1;
    end else begin
      if (ram_we[0]) mem[0][ram_aw[0]] <= ram_dw[0];
      if (ram_we[1]) mem[1][ram_aw[1]] <= ram_dw[1];
    end
    pipe_a    <= mem[0][ram_ar[0]];
    pipe_b[0] <= mem[1][ram_ar[1]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign ram_dr[0] = pipe_a;
  assign ram_dr[1] = pipe_b[2];

  // Event log sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (gnt[d] != 2'b00) gq[d].push_back('{cyc, gnt[d], 8'h00});
      if (rvalid[d] != 2'b00) rq[d].push_back('{cyc, rvalid[d], rdata[d]});
      if (ram_we[d]) we_cnt[d]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (busy[d] && t < 50) begin
      tick(1);
      t++;
    end
    if (busy[d]) check("idle_timeout", 32'(busy[d]), 32'd0);
    tick(2);
  endtask

  task automatic set_cmd(input int d, input int r, input logic w,
                         input logic [4:0] a, input logic [7:0] wd);
    we[d][r]              = w;
    addr[d][r*5 +: 5]     = a;
    wdata[d][r*8 +: 8]    = wd;
  endtask

  // Hold the masked requests until n grants appear, then drop them.
  task automatic burst(input int d, input logic [1:0] mask, input int n);
    int base;
    int t;
    base = gq[d].size();
    t = 0;
    req[d] = mask;
    while ((gq[d].size() - base) < n && t < 100) begin
      tick(1);
      t++;
    end
    req[d] = 2'b00;
    if ((gq[d].size() - base) < n) check("grant_timeout", gq[d].size() - base, n);
    wait_idle(d);
  endtask

  task automatic send(input int d, input int r, input logic w,
                      input logic [4:0] a, input logic [7:0] wd);
    set_cmd(d, r, w, a, wd);
    burst(d, 2'b01 << r, 1);
  endtask

  initial begin
    int base;
    int rbase;
    int t;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req[d]   = '0;
      we[d]    = '0;
      addr[d]  = '0;
      wdata[d] = '0;
    end
    tick(2);
    check("rst_gnt", gnt[0], 0);
    check("rst_rvalid", rvalid[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_ram_we", ram_we[0], 0);
    check("rst_ram_aw", ram_aw[0], 0);
    check("rst_ram_ar", ram_ar[0], 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick(2);

    // Write 0xC5 to 0x1B, then read it back (RD_LAT=1).
    send(0, 0, 1'b1, 5'h1B, 8'hC5);
    check("wr_gnt_cnt", gq[0].size(), 1);
    check("wr_gnt_who", gq[0][0].who, 2'b01);
    check("wr_commit", mem[0][27], 8'hC5);
    check("wr_we_cnt", we_cnt[0], 1);
    send(0, 0, 1'b0, 5'h1B, 8'h00);
    check("rd_gnt_cnt", gq[0].size(), 2);
    check("rd_rv_cnt", rq[0].size(), 1);
    check("rd_rv_who", rq[0][0].who, 2'b01);
    check("rd_data", rq[0][0].data, 8'hC5);
    check("rd_latency", rq[0][0].cyc - gq[0][1].cyc, 2);
    check("rd_hold", rdata[0], 8'hC5);

    // Contention: both requesters read their own words, six grants.
    send(0, 0, 1'b1, 5'd3, 8'h11);
    send(0, 1, 1'b1, 5'd4, 8'h22);
    check("pre_we_cnt", we_cnt[0], 3);
    set_cmd(0, 0, 1'b0, 5'd3, 8'h00);
    set_cmd(0, 1, 1'b0, 5'd4, 8'h00);
    base  = gq[0].size();
    rbase = rq[0].size();
    burst(0, 2'b11, 6);
    check("cont_gnt_cnt", gq[0].size() - base, 6);
    check("cont_rv_cnt", rq[0].size() - rbase, 6);
    for (int k = 0; k < 6; k++) begin
      check("cont_order", gq[0][base+k].who, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_rv_who", rq[0][rbase+k].who, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_data", rq[0][rbase+k].data, (k % 2 == 0) ? 8'h11 : 8'h22);
      if (k > 0) check("cont_spacing", gq[0][base+k].cyc - gq[0][base+k-1].cyc, 3);
    end

    // Withdrawn request: requester 1 pulses req while requester 0 is served.
    set_cmd(0, 0, 1'b0, 5'd3, 8'h00);
    base = gq[0].size();
    req[0] = 2'b01;
    t = 0;
    while (gq[0].size() == base && t < 20) begin
      tick(1);
      t++;
    end
    req[0] = 2'b10;
    tick(1);
    req[0] = 2'b00;
    wait_idle(0);
    tick(4);
    check("wd_gnt_cnt", gq[0].size() - base, 1);
    check("wd_gnt_who", gq[0][base].who, 2'b01);

    // Out of range on instance B (A_MAX=24).
    send(1, 0, 1'b1, 5'd25, 8'hAA);
    check("oor_gnt_cnt", gq[1].size(), 1);
    check("oor_gnt_who", gq[1][0].who, 2'b01);
    check("oor_we_cnt", we_cnt[1], 0);
    check("oor_mem", mem[1][25], 8'h5A);
    send(1, 0, 1'b0, 5'd25, 8'h00);
    check("oor_rv_cnt", rq[1].size(), 1);
    check("oor_rv_who", rq[1][0].who, 2'b01);
    check("oor_rdata", rq[1][0].data, 8'h00);

    // In-range write/read on instance B (RD_LAT=3).
    send(1, 1, 1'b1, 5'd5, 8'h3C);
    check("b_we_cnt", we_cnt[1], 1);
    send(1, 1, 1'b0, 5'd5, 8'h00);
    check("b_rv_cnt", rq[1].size(), 2);
    check("b_rdata", rq[1][1].data, 8'h3C);
    check("b_latency", rq[1][1].cyc - gq[1][3].cyc, 4);

    // Reset during WAIT: asynchronous clear, no rvalid for the lost read.
    set_cmd(1, 0, 1'b0, 5'd5, 8'h00);
    base = gq[1].size();
    req[1] = 2'b01;
    t = 0;
    while (gq[1].size() == base && t < 20) begin
      tick(1);
      t++;
    end
    req[1] = 2'b00;
    tick(1);
    check("pre_rst_busy", busy[1], 1);
    rbase = rq[1].size();
    rst_n[1] = 1'b0;
    #1;
    check("mrst_gnt", gnt[1], 0);
    check("mrst_rvalid", rvalid[1], 0);
    check("mrst_rdata", rdata[1], 0);
    check("mrst_busy", busy[1], 0);
    check("mrst_ram_ar", ram_ar[1], 0);
    check("mrst_ram_aw", ram_aw[1], 0);
    check("mrst_ram_dw", ram_dw[1], 0);
    check("mrst_ram_we", ram_we[1], 0);
    tick(2);
    rst_n[1] = 1'b1;
    tick(8);
    check("mrst_no_rvalid", rq[1].size() - rbase, 0);

    // After reset requester 0 wins first; both reads return the stored word.
    set_cmd(1, 0, 1'b0, 5'd5, 8'h00);
    set_cmd(1, 1, 1'b0, 5'd5, 8'h00);
    base  = gq[1].size();
    rbase = rq[1].size();
    burst(1, 2'b11, 2);
    check("post_gnt_first", gq[1][base].who, 2'b01);
    check("post_gnt_second", gq[1][base+1].who, 2'b10);
    check("post_rv_cnt", rq[1].size() - rbase, 2);
    check("post_rdata0", rq[1][rbase].data, 8'h3C);
    check("post_rdata1", rq[1][rbase+1].data, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_arbiter
